telemetry_rcv: RTL and testbench

Receive end of the telemetry serial link: deserializes the UART stream produced by the telemetry transmitter and reassembles each 8-byte frame (0xAA, 0x55, then batt_v, avg_curr, avg_torque as high-nibble/low-byte pairs) into three 12-bit registered values. It sits on the host/monitor side of the link, or in a loopback bench. It flags every completed frame with a one-cycle strobe and reports framing and protocol errors.

---
 rtl/telem_pkg.sv | 29 ++
 rtl/telem_uart_rx.sv | 118 +++++++++++
 rtl/telemetry_rcv.sv | 150 +++++++++++++++
 tb/tb_telemetry_rcv.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/telem_pkg.sv
// Shared constants and types for the telemetry receiver: sync bytes, frame
// length, frame/byte-receiver state enums and the debug state bundle.
package telem_pkg;

    localparam logic [7:0] SYNC1_BYTE  = 8'hAA;
    localparam logic [7:0] SYNC2_BYTE  = 8'h55;
    localparam int         PAYLOAD_LEN = 6;

    typedef enum logic [1:0] {
        SYNC1   = 2'd0,
        SYNC2   = 2'd1,
        PAYLOAD = 2'd2
    } telem_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    typedef struct packed {
        telem_state_e frame_state;
        logic [2:0]   idx;
        rx_state_e    rx_state;
    } telem_dbg_t;

endpackage

// File: rtl/telem_uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, half-bit start re-check, centre
// sampling of data and stop bits. A bad stop bit waits for RX high to re-arm.
module telem_uart_rx
    import telem_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic       byte_rdy,
    output logic [7:0] byte_data,
    output logic       frm_err,
    output rx_state_e  state_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

    logic [1:0]       sync_q;
    logic             prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             rdy_q, rdy_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], RX};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A start bit that is high again by mid-bit was only a glitch.
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rdy_d   = 1'b1;
                        data_d  = shift_q;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_rdy  = rdy_q;
    assign byte_data = data_q;
    assign frm_err   = ferr_q;
    assign state_o   = state_q;

endmodule

// File: rtl/telemetry_rcv.sv
// Telemetry frame receiver: AA 55 sync, six payload bytes assembled into three
// 12-bit values. TELEM_NIB_CHK_EN enables the zero-upper-nibble payload check.
module telemetry_rcv
    import telem_pkg::*;
#(
    parameter int BAUD_DIV  = 2604,
    parameter int TO_CYCLES = 78120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        pkt_vld,
    output logic        pkt_err,
    output telem_dbg_t  dbg_o
);

    localparam int TO_W = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYCLES);
    localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_LEN - 1);

    logic       byte_rdy;
    logic [7:0] byte_data;
    logic       frm_err;
    rx_state_e  rx_state;

    telem_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .byte_rdy  (byte_rdy),
        .byte_data (byte_data),
        .frm_err   (frm_err),
        .state_o   (rx_state)
    );

    telem_state_e    state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [TO_W-1:0] idle_q, idle_d;
    // Only the bits the assembly uses are kept: low nibbles of b0/b2/b4, full b1/b3.
    logic [3:0]      nib_q [3], nib_d [3];
    logic [7:0]      lo_q  [2], lo_d  [2];
    logic [11:0]     batt_q, batt_d, curr_q, curr_d, torq_q, torq_d;
    logic            vld_q, vld_d, err_q, err_d;
    logic            abort, nib_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC1;
            idx_q   <= '0;
            idle_q  <= '0;
            nib_q   <= '{default: '0};
            lo_q    <= '{default: '0};
            batt_q  <= '0;
            curr_q  <= '0;
            torq_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            nib_q   <= nib_d;
            lo_q    <= lo_d;
            batt_q  <= batt_d;
            curr_q  <= curr_d;
            torq_q  <= torq_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

`ifdef TELEM_NIB_CHK_EN
    assign nib_bad = (state_q == PAYLOAD) && !idx_q[0] && (byte_data[7:4] != 4'h0);
`else
    assign nib_bad = 1'b0;
`endif

    assign abort = (state_q != SYNC1) && (frm_err || (idle_q == TO_MAX));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nib_d   = nib_q;
        lo_d    = lo_q;
        batt_d  = batt_q;
        curr_d  = curr_q;
        torq_d  = torq_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;

        if (state_q == SYNC1 || byte_rdy) begin
            idle_d = '0;
        end else if (idle_q != TO_MAX) begin
            idle_d = idle_q + TO_W'(1);
        end else begin
            idle_d = idle_q;
        end

        if (abort) begin
            state_d = SYNC1;
            idx_d   = '0;
            err_d   = 1'b1;
        end else if (byte_rdy) begin
            case (state_q)
                SYNC1: begin
                    if (byte_data == SYNC1_BYTE) state_d = SYNC2;
                end
                SYNC2: begin
                    if (byte_data == SYNC2_BYTE) begin
                        state_d = PAYLOAD;
                        idx_d   = '0;
                    end else if (byte_data != SYNC1_BYTE) begin
                        state_d = SYNC1;
                    end
                end
                PAYLOAD: begin
                    idx_d = idx_q + 3'd1;
                    if (nib_bad) begin
                        state_d = SYNC1;
                        idx_d   = '0;
                        err_d   = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        batt_d  = {nib_q[0], lo_q[0]};
                        curr_d  = {nib_q[1], lo_q[1]};
                        torq_d  = {nib_q[2], byte_data};
                        vld_d   = 1'b1;
                        state_d = SYNC1;
                        idx_d   = '0;
                    end else if (idx_q[0]) begin
                        lo_d[idx_q[1]] = byte_data;
                    end else begin
                        nib_d[idx_q[2:1]] = byte_data[3:0];
                    end
                end
                default: state_d = SYNC1;
            endcase
        end
    end

    assign batt_v     = batt_q;
    assign avg_curr   = curr_q;
    assign avg_torque = torq_q;
    assign pkt_vld    = vld_q;
    assign pkt_err    = err_q;
    assign dbg_o      = '{frame_state: state_q, idx: idx_q, rx_state: rx_state};

endmodule

// File: tb/tb_telemetry_rcv.sv
// Directed bench for telemetry_rcv with a shortened bit time and timeout.
module tb_telemetry_rcv;
    import telem_pkg::*;

    localparam int BIT = 40;
    localparam int TO  = 1200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [11:0] batt_v, avg_curr, avg_torque;
    logic        pkt_vld, pkt_err;
    telem_dbg_t  dbg;

    telemetry_rcv #(.BAUD_DIV(BIT), .TO_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (rx),
        .batt_v     (batt_v),
        .avg_curr   (avg_curr),
        .avg_torque (avg_torque),
        .pkt_vld    (pkt_vld),
        .pkt_err    (pkt_err),
        .dbg_o      (dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, vld_cnt = 0, err_cnt = 0, both_cnt = 0;
    int vld_cyc = 0, stop_cyc = 0;
    int v0, e0;
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    logic [35:0] exp_v, got_v;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pkt_vld) begin
            vld_cnt++;
            vld_cyc = cyc;
            got_q.push_back({batt_v, avg_curr, avg_torque});
        end
        if (pkt_err) err_cnt++;
        if (pkt_vld && pkt_err) both_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int bl, input int gap);
        rx = 1'b0;
        repeat (bl) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bl) @(negedge clk);
        end
        rx = stop_val;
        stop_cyc = cyc;
        repeat (bl) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [11:0] a, input logic [11:0] c, input logic [11:0] t,
                              input int bl, input int gap);
        logic [7:0] f [8];
        f = '{8'hAA, 8'h55, {4'h0, a[11:8]}, a[7:0], {4'h0, c[11:8]}, c[7:0], {4'h0, t[11:8]}, t[7:0]};
        exp_q.push_back({a, c, t});
        for (int i = 0; i < 8; i++) send_byte(f[i], 1'b1, bl, gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({batt_v, avg_curr, avg_torque} !== 36'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", {batt_v, avg_curr, avg_torque}, 36'h0); end
        n_cmp++; if (pkt_vld !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_vld: got %b expected 0", pkt_vld); end
        n_cmp++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_err: got %b expected 0", pkt_err); end
        n_cmp++; if (dbg.frame_state !== SYNC1) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg.frame_state, SYNC1); end
    endtask

    task automatic test_good_frame();
        got_q.delete(); exp_q.delete(); v0 = vld_cnt; e0 = err_cnt;
        send_frame(12'hABC, 12'h123, 12'h567, BIT, BIT);
        n_cmp++; if (vld_cyc - stop_cyc !== BIT / 2 + 4) begin n_fail++; $display("FAIL good_latency: got %0d expected %0d", vld_cyc - stop_cyc, BIT / 2 + 4); end
        send_frame(12'hABC, 12'h123, 12'h567, BIT, BIT);
        n_cmp++; if (vld_cnt - v0 !== 2) begin n_fail++; $display("FAIL good_vld_count: got %0d expected 2", vld_cnt - v0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL good_err_count: got %0d expected 0", err_cnt - e0); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++; if (got_v !== exp_v) begin n_fail++; $display("FAIL good_values: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete(); exp_q.delete(); v0 = vld_cnt; e0 = err_cnt;
        send_frame(12'h321, 12'hFED, 12'h0AA, BIT, 0);
        send_frame(12'h000, 12'hFFF, 12'h855, BIT, 0);
        repeat (2 * BIT) @(negedge clk);
        n_cmp++; if (vld_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_vld_count: got %0d expected 2", vld_cnt - v0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_err_count: got %0d expected 0", err_cnt - e0); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++; if (got_v !== exp_v) begin n_fail++; $display("FAIL b2b_values: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_resync();
        logic [7:0] s [10];
        s = '{8'h13, 8'hAA, 8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h05, 8'h67};
        got_q.delete(); exp_q.delete(); v0 = vld_cnt; e0 = err_cnt;
        for (int i = 0; i < 10; i++) send_byte(s[i], 1'b1, BIT, BIT);
        n_cmp++; if (vld_cnt - v0 !== 1) begin n_fail++; $display("FAIL resync_vld_count: got %0d expected 1", vld_cnt - v0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL resync_err_count: got %0d expected 0", err_cnt - e0); end
        got_v = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++; if (got_v !== 36'hABC_123_567) begin n_fail++; $display("FAIL resync_values: got %h expected %h", got_v, 36'hABC_123_567); end
    endtask

    task automatic test_frame_error();
        logic [7:0] s [8];
        s = '{8'hAA, 8'h55, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33};
        got_q.delete(); exp_q.delete(); v0 = vld_cnt; e0 = err_cnt;
        for (int i = 0; i < 8; i++) send_byte(s[i], (i == 5) ? 1'b0 : 1'b1, BIT, (i == 5) ? 2 * BIT : BIT);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_err_count: got %0d expected 1", err_cnt - e0); end
        n_cmp++; if (vld_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_vld_count: got %0d expected 0", vld_cnt - v0); end
        n_cmp++; if ({batt_v, avg_curr, avg_torque} !== 36'hABC_123_567) begin n_fail++; $display("FAIL ferr_hold: got %h expected %h", {batt_v, avg_curr, avg_torque}, 36'hABC_123_567); end
        v0 = vld_cnt;
        send_frame(12'h456, 12'h789, 12'hABC, BIT, BIT);
        n_cmp++; if (vld_cnt - v0 !== 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d expected 1", vld_cnt - v0); end
        exp_v = exp_q.pop_front();
        got_v = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++; if (got_v !== exp_v) begin n_fail++; $display("FAIL ferr_recover_values: got %h expected %h", got_v, exp_v); end
    endtask

    task automatic test_timeout();
        got_q.delete(); exp_q.delete(); v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'hAA, 1'b1, BIT, 0);
        send_byte(8'h55, 1'b1, BIT, 0);
        send_byte(8'h0A, 1'b1, BIT, 0);
        repeat (TO + 100) @(negedge clk);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL to_err_count: got %0d expected 1", err_cnt - e0); end
        n_cmp++; if (dbg.frame_state !== SYNC1) begin n_fail++; $display("FAIL to_state: got %0d expected %0d", dbg.frame_state, SYNC1); end
        n_cmp++; if ({batt_v, avg_curr, avg_torque} !== 36'h456_789_ABC) begin n_fail++; $display("FAIL to_hold: got %h expected %h", {batt_v, avg_curr, avg_torque}, 36'h456_789_ABC); end
        // Inter-byte gaps just below the timeout must not abort the frame.
        e0 = err_cnt;
        send_frame(12'hDEF, 12'h012, 12'h345, BIT, TO - 12 * BIT);
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL to_slow_err: got %0d expected 0", err_cnt - e0); end
        n_cmp++; if (vld_cnt - v0 !== 1) begin n_fail++; $display("FAIL to_slow_vld: got %0d expected 1", vld_cnt - v0); end
        exp_v = exp_q.pop_front();
        got_v = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++; if (got_v !== exp_v) begin n_fail++; $display("FAIL to_slow_values: got %h expected %h", got_v, exp_v); end
    endtask

    task automatic test_nib_check();
        logic [7:0] s [8];
        s = '{8'hAA, 8'h55, 8'hFA, 8'hBC, 8'h01, 8'h23, 8'h05, 8'h67};
        got_q.delete(); exp_q.delete(); v0 = vld_cnt; e0 = err_cnt;
        for (int i = 0; i < 8; i++) send_byte(s[i], 1'b1, BIT, BIT);
`ifdef TELEM_NIB_CHK_EN
        n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL nib_err_count: got %0d expected 1", err_cnt - e0); end
        n_cmp++; if (vld_cnt - v0 !== 0) begin n_fail++; $display("FAIL nib_vld_count: got %0d expected 0", vld_cnt - v0); end
        n_cmp++; if ({batt_v, avg_curr, avg_torque} !== 36'hDEF_012_345) begin n_fail++; $display("FAIL nib_hold: got %h expected %h", {batt_v, avg_curr, avg_torque}, 36'hDEF_012_345); end
`else
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL nib_err_count: got %0d expected 0", err_cnt - e0); end
        n_cmp++; if (vld_cnt - v0 !== 1) begin n_fail++; $display("FAIL nib_vld_count: got %0d expected 1", vld_cnt - v0); end
        n_cmp++; if (batt_v !== 12'hABC) begin n_fail++; $display("FAIL nib_batt: got %h expected %h", batt_v, 12'hABC); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        got_q.delete(); exp_q.delete(); v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'hAA, 1'b1, BIT, BIT);
        send_byte(8'h55, 1'b1, BIT, BIT);
        send_byte(8'h0A, 1'b1, BIT, BIT);
        send_byte(8'hBC, 1'b1, BIT, BIT);
        fork
            begin
                send_byte(8'h01, 1'b1, BIT, BIT);
                send_byte(8'h23, 1'b1, BIT, BIT);
                send_byte(8'h05, 1'b1, BIT, BIT);
                send_byte(8'h67, 1'b1, BIT, BIT);
            end
            begin
                repeat (3 * BIT + 5) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                n_cmp++; if ({batt_v, avg_curr, avg_torque} !== 36'h0) begin n_fail++; $display("FAIL rstmid_outputs: got %h expected %h", {batt_v, avg_curr, avg_torque}, 36'h0); end
            end
        join
        repeat (20 * BIT) @(negedge clk);
        n_cmp++; if (vld_cnt - v0 !== 0) begin n_fail++; $display("FAIL rstmid_vld_count: got %0d expected 0", vld_cnt - v0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL rstmid_err_count: got %0d expected 0", err_cnt - e0); end
        send_frame(12'hABC, 12'h123, 12'h567, BIT, BIT);
        n_cmp++; if (vld_cnt - v0 !== 1) begin n_fail++; $display("FAIL rstmid_recover_count: got %0d expected 1", vld_cnt - v0); end
        exp_v = exp_q.pop_front();
        got_v = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++; if (got_v !== exp_v) begin n_fail++; $display("FAIL rstmid_values: got %h expected %h", got_v, exp_v); end
    endtask

    task automatic test_baud_tolerance();
        got_q.delete(); exp_q.delete(); v0 = vld_cnt; e0 = err_cnt;
        send_frame(12'h135, 12'h246, 12'h9BD, BIT - 1, BIT);
        send_frame(12'hFFF, 12'h000, 12'h7E5, BIT + 1, BIT);
        n_cmp++; if (vld_cnt - v0 !== 2) begin n_fail++; $display("FAIL tol_vld_count: got %0d expected 2", vld_cnt - v0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL tol_err_count: got %0d expected 0", err_cnt - e0); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++; if (got_v !== exp_v) begin n_fail++; $display("FAIL tol_values: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_strobe_exclusive();
        n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_resync();
        test_frame_error();
        test_timeout();
        test_nib_check();
        test_reset_mid_frame();
        test_baud_tolerance();
        test_strobe_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
